// File: rtl/tinker_pkg.sv
// Shared Tinker definitions: opcodes, instruction field positions, issue FSM states
// and the combinational operand/destination decoder used by the issue stage.
package tinker_pkg;

  localparam logic [4:0] OP_ADD = 5'h00;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h06;
  localparam logic [4:0] OP_OR  = 5'h07;
  localparam logic [4:0] OP_XOR = 5'h08;
  localparam logic [4:0] OP_NOT = 5'h09;
  localparam logic [4:0] OP_SHL = 5'h0A;
  localparam logic [4:0] OP_MOV = 5'h17;
  localparam logic [4:0] OP_LD  = 5'h1D;
  localparam logic [4:0] OP_ST  = 5'h1E;
  localparam logic [4:0] OP_NOP = 5'h1F;

  localparam logic [31:0] NOP_WORD = 32'h0000001F;

  localparam int OP_LSB = 0;
  localparam int A_LSB  = 5;
  localparam int B_LSB  = 10;
  localparam int C_LSB  = 15;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic       legal;
    logic       has_dest;
    logic [4:0] dest;
    logic       src0_v;
    logic [4:0] src0;
    logic       src1_v;
    logic [4:0] src1;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] word);
    decode_t    d;
    logic [4:0] op;
    logic [4:0] fa;
    logic [4:0] fb;
    logic [4:0] fc;
    op = word[OP_LSB +: 5];
    fa = word[A_LSB +: 5];
    fb = word[B_LSB +: 5];
    fc = word[C_LSB +: 5];
    d = '0;
    d.legal = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
        d.has_dest = 1'b1; d.dest = fa;
        d.src0_v = 1'b1; d.src0 = fb;
        d.src1_v = 1'b1; d.src1 = fc;
      end
      OP_NOT: begin
        d.has_dest = 1'b1; d.dest = fa;
        d.src0_v = 1'b1; d.src0 = fb;
      end
      OP_MOV: begin
        d.has_dest = 1'b1; d.dest = fa;
      end
      OP_ST: begin
        d.src0_v = 1'b1; d.src0 = fa;
        d.src1_v = 1'b1; d.src1 = fb;
      end
      OP_LD: begin
        d.has_dest = 1'b1; d.dest = fb;
        d.src0_v = 1'b1; d.src0 = fa;
      end
      OP_NOP: ;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Shift-register scoreboard of pending register-file writebacks; flags a hazard when
// either source address matches a pending destination.
module wb_scoreboard
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_v,
  input  logic [4:0] push_addr,
  input  logic       src0_v,
  input  logic [4:0] src0,
  input  logic       src1_v,
  input  logic [4:0] src1,
  output logic       hazard,
  output logic       empty
);

  // A writeback is readable in the register stage DEPTH cycles after issue, so the
  // entry retires on the edge it becomes visible: DEPTH-1 live stages remain.
  localparam int STAGES = (DEPTH > 1) ? DEPTH - 1 : 1;

  logic [STAGES-1:0] v_reg;
  logic [4:0]        addr_reg [STAGES];
  logic [STAGES-1:0] hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg <= '0;
    end else begin
      v_reg[0] <= push_v;
      for (int i = 1; i < STAGES; i++) begin
        v_reg[i] <= v_reg[i-1];
      end
    end
    addr_reg[0] <= push_addr;
    for (int i = 1; i < STAGES; i++) begin
      addr_reg[i] <= addr_reg[i-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_hit
    assign hit[gi] = v_reg[gi] &&
                     ((src0_v && (src0 == addr_reg[gi])) ||
                      (src1_v && (src1 == addr_reg[gi])));
  end

  assign hazard = |hit;
  assign empty  = ~|v_reg;

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between fetch and decode: accepts words over valid/ready, issues
// one word or a NOP bubble per cycle, stalls on RAW hazards and drains on halt.
module issue_ctrl
  import tinker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             halt_req,
  output logic [31:0]      issue_instr,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  decode_t    dec;
  state_t     state_reg, state_next;
  logic       hazard_raw;
  logic       hazard;
  logic       sb_empty;
  logic       accept;
  logic       push_v;
  logic       stall_inc;
  logic       illegal_next;
  logic [31:0] issue_next;

  logic [31:0]      issue_reg;
  logic             halted_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] stall_reg;

  assign dec    = decode_instr(instr);
  // Illegal words never wait on the scoreboard.
  assign hazard = hazard_raw && dec.legal;
  assign accept = instr_valid && instr_ready;
  assign push_v = accept && dec.has_dest;

  wb_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .push_v    (push_v),
    .push_addr (dec.dest),
    .src0_v    (dec.src0_v),
    .src0      (dec.src0),
    .src1_v    (dec.src1_v),
    .src1      (dec.src1),
    .hazard    (hazard_raw),
    .empty     (sb_empty)
  );

  always_comb begin
    state_next   = state_reg;
    instr_ready  = 1'b0;
    issue_next   = NOP_WORD;
    illegal_next = 1'b0;
    stall_inc    = 1'b0;
    case (state_reg)
      RUN: begin
        instr_ready = !halt_req && !hazard;
        if (instr_valid && instr_ready) begin
          issue_next   = dec.legal ? instr : NOP_WORD;
          illegal_next = !dec.legal;
        end
        stall_inc = instr_valid && !instr_ready;
        if (halt_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (sb_empty) state_next = HALTED;
      end
      HALTED: begin
        if (!halt_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      issue_reg   <= NOP_WORD;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      stall_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      issue_reg   <= issue_next;
      halted_reg  <= (state_next == HALTED);
      illegal_reg <= illegal_next;
      if (stall_inc && (stall_reg != '1)) stall_reg <= stall_reg + 1'b1;
    end
  end

  assign issue_instr = issue_reg;
  assign halted      = halted_reg;
  assign illegal     = illegal_reg;
  assign stall_cnt   = stall_reg;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: expected issue words are queued as each cycle is
// driven and compared after the edge; control outputs are checked at fixed points.
module tb_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000001F;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        halt_req;
  logic [31:0] issue_instr;
  logic        halted;
  logic        illegal;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .halt_req    (halt_req),
    .issue_instr (issue_instr),
    .halted      (halted),
    .illegal     (illegal),
    .stall_cnt   (stall_cnt)
  );

  function automatic logic is_legal(input logic [31:0] w);
    logic [4:0] op;
    op = w[4:0];
    return (op == 5'h00) || (op == 5'h02) || (op == 5'h06) || (op == 5'h07) ||
           (op == 5'h08) || (op == 5'h09) || (op == 5'h0A) || (op == 5'h17) ||
           (op == 5'h1D) || (op == 5'h1E) || (op == 5'h1F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check ready mid-cycle, queue expected word, compare after edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic h,
                     input logic exp_rdy, input string tag);
    logic [31:0] exp_w;
    instr_valid = v;
    instr       = w;
    halt_req    = h;
    @(negedge clk);
    chk({tag, ".ready"}, {31'b0, instr_ready}, {31'b0, exp_rdy});
    exp_q.push_back((v && exp_rdy) ? (is_legal(w) ? w : NOP) : NOP);
    @(posedge clk);
    #1;
    exp_w = exp_q.pop_front();
    chk({tag, ".issue"}, issue_instr, exp_w);
    $display("[TB] %s v=%0b instr=%h halt=%0b -> ready=%0b issue=%h", tag, v, w, h,
             instr_ready, issue_instr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, NOP, 1'b0, 1'b1, "idle");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = NOP; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.issue",   issue_instr, NOP);
    chk("rst.halted",  {31'b0, halted}, 32'd0);
    chk("rst.illegal", {31'b0, illegal}, 32'd0);
    chk("rst.stall",   {16'b0, stall_cnt}, 32'd0);
    rst = 1'b0;

    // Independent pair issues back to back.
    cyc(1'b1, 32'h00010460, 1'b0, 1'b1, "ind0");
    cyc(1'b1, 32'h000104C0, 1'b0, 1'b1, "ind1");
    chk("ind.stall", {16'b0, stall_cnt}, 32'd0);
    idle(3);

    // RAW on r3: three bubbles.
    cyc(1'b1, 32'h00010460, 1'b0, 1'b1, "raw0");
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h00018C80, 1'b0, 1'b0, "raw_wait");
    cyc(1'b1, 32'h00018C80, 1'b0, 1'b1, "raw1");
    chk("raw.stall", {16'b0, stall_cnt}, 32'd3);
    idle(3);

    // mov r5 then st r5->r6.
    cyc(1'b1, 32'h123000B7, 1'b0, 1'b1, "mov");
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h000018BE, 1'b0, 1'b0, "st_wait");
    cyc(1'b1, 32'h000018BE, 1'b0, 1'b1, "st");
    chk("movst.stall", {16'b0, stall_cnt}, 32'd6);
    idle(3);

    // ld writes r5 (field B); add reading r0 is independent.
    cyc(1'b1, 32'h0000141D, 1'b0, 1'b1, "ld");
    cyc(1'b1, 32'h00000060, 1'b0, 1'b1, "add_r0");
    chk("ld.stall", {16'b0, stall_cnt}, 32'd6);
    idle(3);

    // Illegal opcode: accepted, NOP issued, one-cycle pulse, nothing pushed.
    chk("pre_ill.illegal", {31'b0, illegal}, 32'd0);
    cyc(1'b1, 32'h00000005, 1'b0, 1'b1, "ill");
    chk("ill.pulse", {31'b0, illegal}, 32'd1);
    cyc(1'b1, 32'h00000060, 1'b0, 1'b1, "after_ill");
    chk("ill.clear", {31'b0, illegal}, 32'd0);
    idle(3);

    // Halt: halt wins over a clean word, drain, hold, resume.
    cyc(1'b1, 32'h00010460, 1'b0, 1'b1, "h_add");
    cyc(1'b1, 32'h000104C0, 1'b1, 1'b0, "h_req");
    chk("h_req.stall", {16'b0, stall_cnt}, 32'd7);
    chk("h_req.halted", {31'b0, halted}, 32'd0);
    cyc(1'b1, 32'h000104C0, 1'b1, 1'b0, "drain1");
    chk("drain1.halted", {31'b0, halted}, 32'd0);
    cyc(1'b1, 32'h000104C0, 1'b1, 1'b0, "drain2");
    chk("drain2.halted", {31'b0, halted}, 32'd0);
    cyc(1'b1, 32'h000104C0, 1'b1, 1'b0, "drain3");
    chk("drain3.halted", {31'b0, halted}, 32'd1);
    cyc(1'b1, 32'h000104C0, 1'b1, 1'b0, "hold");
    chk("hold.halted", {31'b0, halted}, 32'd1);
    cyc(1'b1, 32'h000104C0, 1'b0, 1'b0, "release");
    chk("release.halted", {31'b0, halted}, 32'd0);
    cyc(1'b1, 32'h000104C0, 1'b0, 1'b1, "resume");
    chk("resume.stall", {16'b0, stall_cnt}, 32'd7);
    idle(3);

    // Reset in the middle of a RAW stall.
    cyc(1'b1, 32'h00010460, 1'b0, 1'b1, "rr0");
    cyc(1'b1, 32'h00018C80, 1'b0, 1'b0, "rr_wait");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst.issue",  issue_instr, NOP);
    chk("mid_rst.stall",  {16'b0, stall_cnt}, 32'd0);
    chk("mid_rst.halted", {31'b0, halted}, 32'd0);
    rst = 1'b0;
    cyc(1'b1, 32'h00018C80, 1'b0, 1'b1, "rr1");
    chk("rr1.stall", {16'b0, stall_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
